// File: rtl/riscv_pkg.sv
// Shared RV32I control-path types: FSM states, opcode classes, opcode and ALUOp encodings.
package riscv_pkg;

    localparam int RV_OPCODE_W = 7;

    localparam logic [RV_OPCODE_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [RV_OPCODE_W-1:0] OPC_I      = 7'b0010011;
    localparam logic [RV_OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [RV_OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [RV_OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [RV_OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [RV_OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [RV_OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [RV_OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALUOP_I      = 3'b000;
    localparam logic [2:0] ALUOP_STORE  = 3'b001;
    localparam logic [2:0] ALUOP_UPPER  = 3'b010;
    localparam logic [2:0] ALUOP_BRANCH = 3'b011;
    localparam logic [2:0] ALUOP_JAL    = 3'b100;
    localparam logic [2:0] ALUOP_R      = 3'b101;
    localparam logic [2:0] ALUOP_LOAD   = 3'b110;
    localparam logic [2:0] ALUOP_JALR   = 3'b111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } mc_state_t;

    typedef enum logic [3:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JALR, OP_JAL, OP_LUI, OP_AUIPC, OP_ILLEGAL
    } opclass_t;

    typedef struct packed {
        logic       jump_reg;
        logic       jump;
        logic       reg_src1;
        logic       reg_src2;
        logic       upper_imm;
        logic       mem_to_reg;
        logic       ret_addr;
        logic [2:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decode into an opcode class and the level-control bundle.
module opcode_classifier
    import riscv_pkg::*;
(
    input  logic [RV_OPCODE_W-1:0] opcode,
    output opclass_t               op_class,
    output ctrl_t                  ctrl
);

    always_comb begin
        op_class = OP_ILLEGAL;
        ctrl     = '0;
        case (opcode)
            OPC_R: begin
                op_class      = OP_R;
                ctrl.reg_src1 = 1'b1;
                ctrl.reg_src2 = 1'b1;
                ctrl.alu_op   = ALUOP_R;
            end
            OPC_I: begin
                op_class      = OP_I;
                ctrl.reg_src1 = 1'b1;
                ctrl.alu_op   = ALUOP_I;
            end
            OPC_LOAD: begin
                op_class        = OP_LOAD;
                ctrl.reg_src1   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALUOP_LOAD;
            end
            OPC_STORE: begin
                op_class      = OP_STORE;
                ctrl.reg_src1 = 1'b1;
                ctrl.alu_op   = ALUOP_STORE;
            end
            OPC_BRANCH: begin
                op_class      = OP_BRANCH;
                ctrl.reg_src1 = 1'b1;
                ctrl.reg_src2 = 1'b1;
                ctrl.alu_op   = ALUOP_BRANCH;
            end
            OPC_JALR: begin
                op_class      = OP_JALR;
                ctrl.jump_reg = 1'b1;
                ctrl.ret_addr = 1'b1;
                ctrl.alu_op   = ALUOP_JALR;
            end
            OPC_JAL: begin
                op_class      = OP_JAL;
                ctrl.jump     = 1'b1;
                ctrl.ret_addr = 1'b1;
                ctrl.alu_op   = ALUOP_JAL;
            end
            OPC_LUI: begin
                op_class       = OP_LUI;
                ctrl.upper_imm = 1'b1;
                ctrl.alu_op    = ALUOP_UPPER;
            end
            OPC_AUIPC: begin
                op_class    = OP_AUIPC;
                ctrl.alu_op = ALUOP_UPPER;
            end
            // Anything unrecognised is trapped rather than executed as garbage.
            default: begin
                op_class = OP_ILLEGAL;
                ctrl     = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM with memory handshake, illegal/timeout traps and retire counter.
module multicycle_control_fsm
    import riscv_pkg::*;
#(
    parameter int OPCODE_SIZE = RV_OPCODE_W,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OPCODE_SIZE-1:0] Opcode,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   IRWrite,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   RegWrite,
    output logic                   JumpReg,
    output logic                   Jump,
    output logic                   Branch,
    output logic                   RegSrc1,
    output logic                   RegSrc2,
    output logic                   UpperImm,
    output logic                   MemToReg,
    output logic                   RetAddr,
    output logic [2:0]             ALUOp,
    output logic                   illegal,
    output logic                   bus_timeout,
    output logic [CNT_W-1:0]       retired,
    output logic [2:0]             state
);

    localparam int WD_W = $clog2(MEM_TIMEOUT + 2);

    mc_state_t        state_q, state_d;
    opclass_t         class_q, class_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic             bus_timeout_q, bus_timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;

    opclass_t dec_class;
    ctrl_t    dec_ctrl;
    logic     wait_cyc;
    logic     wd_expire;
    logic     retire;

    opcode_classifier u_classifier (
        .opcode   (Opcode[RV_OPCODE_W-1:0]),
        .op_class (dec_class),
        .ctrl     (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            class_q       <= OP_ILLEGAL;
            ctrl_q        <= '0;
            illegal_q     <= 1'b0;
            bus_timeout_q <= 1'b0;
            retired_q     <= '0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            class_q       <= class_d;
            ctrl_q        <= ctrl_d;
            illegal_q     <= illegal_d;
            bus_timeout_q <= bus_timeout_d;
            retired_q     <= retired_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        class_d       = class_q;
        ctrl_d        = ctrl_q;
        illegal_d     = illegal_q;
        bus_timeout_d = bus_timeout_q;
        retire        = 1'b0;
        wait_cyc      = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
        // Expiry is judged on the wait cycle that would bring the count to MEM_TIMEOUT.
        wd_expire     = (MEM_TIMEOUT != 0) && wait_cyc
                        && (int'(wd_cnt_q) == MEM_TIMEOUT - 1);

        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                class_d = dec_class;
                ctrl_d  = dec_ctrl;
                if (dec_class == OP_ILLEGAL) begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (class_q)
                    OP_BRANCH: begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end
                    OP_LOAD, OP_STORE: state_d = MEM;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (class_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = TRAP;
        endcase

        if (wd_expire) begin
            state_d       = TRAP;
            bus_timeout_d = 1'b1;
        end

        wd_cnt_d  = (wait_cyc && !wd_expire && (MEM_TIMEOUT != 0)) ? wd_cnt_q + 1'b1 : '0;
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            EXEC: begin
                Branch  = (class_q == OP_BRANCH);
                PCWrite = (class_q == OP_JAL) || (class_q == OP_JALR);
            end
            MEM: begin
                MemRead  = (class_q == OP_LOAD);
                MemWrite = (class_q == OP_STORE);
            end
            WB:      RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign JumpReg     = ctrl_q.jump_reg;
    assign Jump        = ctrl_q.jump;
    assign RegSrc1     = ctrl_q.reg_src1;
    assign RegSrc2     = ctrl_q.reg_src2;
    assign UpperImm    = ctrl_q.upper_imm;
    assign MemToReg    = ctrl_q.mem_to_reg;
    assign RetAddr     = ctrl_q.ret_addr;
    assign ALUOp       = ctrl_q.alu_op;
    assign illegal     = illegal_q;
    assign bus_timeout = bus_timeout_q;
    assign retired     = retired_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a 4-cycle memory watchdog.
module tb_multicycle_control_fsm;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  Opcode;
    logic        mem_ready;
    logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic        JumpReg, Jump, Branch, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr;
    logic [2:0]  ALUOp;
    logic        illegal, bus_timeout;
    logic [31:0] retired;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    multicycle_control_fsm #(
        .OPCODE_SIZE (7),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Opcode      (Opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .IRWrite     (IRWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .JumpReg     (JumpReg),
        .Jump        (Jump),
        .Branch      (Branch),
        .RegSrc1     (RegSrc1),
        .RegSrc2     (RegSrc2),
        .UpperImm    (UpperImm),
        .MemToReg    (MemToReg),
        .RetAddr     (RetAddr),
        .ALUOp       (ALUOp),
        .illegal     (illegal),
        .bus_timeout (bus_timeout),
        .retired     (retired),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    function automatic logic [31:0] strb();
        return {27'b0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite};
    endfunction

    // {JumpReg, Jump, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr}
    function automatic logic [31:0] lvl();
        return {25'b0, JumpReg, Jump, RegSrc1, RegSrc2, UpperImm, MemToReg, RetAddr};
    endfunction

    function automatic logic [31:0] st();
        return {29'b0, state};
    endfunction

    function automatic logic [31:0] flags();
        return {30'b0, illegal, bus_timeout};
    endfunction

    initial begin
        rst = 1'b1; mem_ready = 1'b0; Opcode = 7'b0;
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_state", st(), int'(FETCH));
        check("rst_strb", strb(), 'b00100);
        check("rst_lvl", lvl(), 0);
        check("rst_alu", {29'b0, ALUOp}, 0);
        check("rst_retired", retired, 0);
        check("rst_flags", flags(), 0);
        $display("txn reset");

        // R-type, memory always ready
        mem_ready = 1'b1; Opcode = 7'b0110011; #1;
        check("r_c1_strb", strb(), 'b11100);
        tick();
        check("r_c2_state", st(), int'(DECODE));
        check("r_c2_strb", strb(), 0);
        tick();
        check("r_c3_state", st(), int'(EXEC));
        check("r_c3_alu", {29'b0, ALUOp}, 'b101);
        check("r_c3_lvl", lvl(), 'b0011000);
        check("r_c3_strb", strb(), 0);
        check("r_c3_branch", {31'b0, Branch}, 0);
        tick();
        check("r_c4_state", st(), int'(WB));
        check("r_c4_strb", strb(), 'b00001);
        check("r_c4_retired", retired, 0);
        tick();
        check("r_c5_state", st(), int'(FETCH));
        check("r_retired", retired, 1);
        $display("txn R-type retired=%0d", retired);

        // LW with three wait cycles in MEM
        Opcode = 7'b0000011;
        tick(); tick();
        check("lw_alu", {29'b0, ALUOp}, 'b110);
        check("lw_lvl", lvl(), 'b0010010);
        tick();
        mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_state", st(), int'(MEM));
            check("lw_wait_strb", strb(), 'b00100);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("lw_ready_strb", strb(), 'b00100);
        tick();
        check("lw_wb_state", st(), int'(WB));
        check("lw_wb_strb", strb(), 'b00001);
        tick();
        check("lw_end_state", st(), int'(FETCH));
        check("lw_retired", retired, 2);
        $display("txn LW retired=%0d", retired);

        // SW then BEQ
        Opcode = 7'b0100011;
        tick(); tick();
        check("sw_alu", {29'b0, ALUOp}, 'b001);
        tick();
        check("sw_mem_strb", strb(), 'b00010);
        tick();
        check("sw_end_state", st(), int'(FETCH));
        check("sw_retired", retired, 3);
        $display("txn SW retired=%0d", retired);
        Opcode = 7'b1100011;
        tick(); tick();
        check("beq_state", st(), int'(EXEC));
        check("beq_branch", {31'b0, Branch}, 1);
        check("beq_alu", {29'b0, ALUOp}, 'b011);
        check("beq_lvl", lvl(), 'b0011000);
        tick();
        check("beq_end_state", st(), int'(FETCH));
        check("beq_retired", retired, 4);
        $display("txn BEQ retired=%0d", retired);

        // JAL
        Opcode = 7'b1101111;
        tick(); tick();
        check("jal_strb", strb(), 'b10000);
        check("jal_lvl", lvl(), 'b0100001);
        check("jal_alu", {29'b0, ALUOp}, 'b100);
        tick();
        check("jal_wb_strb", strb(), 'b00001);
        tick();
        check("jal_retired", retired, 5);
        $display("txn JAL retired=%0d", retired);

        // Illegal opcode traps and stays trapped
        Opcode = 7'b1111111;
        tick();
        check("ill_decode", st(), int'(DECODE));
        tick();
        check("ill_state", st(), int'(TRAP));
        check("ill_flags", flags(), 'b10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ill_hold_state", st(), int'(TRAP));
            check("ill_hold_flags", flags(), 'b10);
            check("ill_hold_strb", strb(), 0);
            check("ill_hold_retired", retired, 5);
        end
        mem_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ill_rst_state", st(), int'(FETCH));
        check("ill_rst_flags", flags(), 0);
        check("ill_rst_retired", retired, 0);
        $display("txn illegal trap cleared by reset");

        // Watchdog expiry in FETCH after 4 wait cycles
        for (int i = 0; i < 4; i++) begin
            check("wd_wait_state", st(), int'(FETCH));
            tick();
        end
        check("wd_trap_state", st(), int'(TRAP));
        check("wd_trap_flags", flags(), 'b01);
        $display("txn fetch timeout");

        // mem_ready on the 4th wait cycle wins over expiry
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wd2_rst_flags", flags(), 0);
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b1; Opcode = 7'b0010011; #1;
        check("wd2_c4_state", st(), int'(FETCH));
        check("wd2_c4_strb", strb(), 'b11100);
        tick();
        check("wd2_decode", st(), int'(DECODE));
        check("wd2_flags", flags(), 0);
        tick();
        check("i_alu", {29'b0, ALUOp}, 'b000);
        check("i_lvl", lvl(), 'b0010000);
        tick(); tick();
        check("i_retired", retired, 1);
        $display("txn late-ready fetch then I-type retired=%0d", retired);

        // Reset in the middle of a stalled store
        Opcode = 7'b0100011;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        check("swr_mem_strb", strb(), 'b00010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("swr_state", st(), int'(FETCH));
        check("swr_strb", strb(), 'b00100);
        check("swr_retired", retired, 0);
        $display("txn reset mid-store");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
